// File: rtl/clock_pkg.sv
// Shared types, digit limits and load validation for the
// time-of-day and alarm-setting blocks.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    RESP
  } state_t;

  localparam logic [2:0] SEC_TENS_MAX = 3'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [1:0] HOUR_TENS_MAX = 2'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;

  typedef struct packed {
    logic [1:0] hl;
    logic [3:0] hr;
    logic [2:0] ml;
    logic [3:0] mr;
    logic [2:0] sl;
    logic [3:0] sr;
  } tod_t;

  function automatic logic load_ok(
    input logic [1:0] hl,
    input logic [3:0] hr,
    input logic [2:0] ml,
    input logic [3:0] mr
  );
    logic ok;
    ok = (hl <= HOUR_TENS_MAX)
      && (hr <= UNITS_MAX)
      && (ml <= SEC_TENS_MAX)
      && (mr <= UNITS_MAX);
    if (hl == HOUR_TENS_MAX &&
        hr > HOUR_UNITS_MAX_AT_20)
      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Load handshake between the time-setting logic
// and the time-of-day core.
interface time_keeper_if;
  logic       load_valid;
  logic [1:0] i_hours_left;
  logic [3:0] i_hours_right;
  logic [2:0] i_minutes_left;
  logic [3:0] i_minutes_right;
  logic       load_ack;
  logic       load_err;

  modport master (
    output load_valid,
    output i_hours_left,
    output i_hours_right,
    output i_minutes_left,
    output i_minutes_right,
    input  load_ack,
    input  load_err
  );

  modport slave (
    input  load_valid,
    input  i_hours_left,
    input  i_hours_right,
    input  i_minutes_left,
    input  i_minutes_right,
    output load_ack,
    output load_err
  );
endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and flags the
// terminal count of each second.
module tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);
  localparam int W =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST =
    W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/time_keeper.sv
// BCD hh:mm:ss time-of-day core with 1 Hz prescaler
// and validated hours/minutes load.
module time_keeper
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  time_keeper_if.slave ld,
  output logic [1:0]   o_hours_left,
  output logic [3:0]   o_hours_right,
  output logic [2:0]   o_minutes_left,
  output logic [3:0]   o_minutes_right,
  output logic [2:0]   o_seconds_left,
  output logic [3:0]   o_seconds_right,
  output logic         sec_pulse,
  output logic         day_wrap
);
  state_t state, nxt;
  tod_t   t, t_inc;
  logic   fire, ok, tick, en, clr, wrap;
  logic   ack_q, err_q;

  assign fire = ld.load_valid && (state != RESP);
  assign ok = load_ok(ld.i_hours_left,
                      ld.i_hours_right,
                      ld.i_minutes_left,
                      ld.i_minutes_right);

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clear(clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      RUN:  nxt = fire ? RESP : (hold ? HOLD : RUN);
      HOLD: nxt = fire ? RESP : (hold ? HOLD : RUN);
      RESP: nxt = hold ? HOLD : RUN;
      default: nxt = RUN;
    endcase
  end

  // A load in the tick cycle wins: the prescaler
  // is stalled so the tick never fires.
  always_comb begin
    en  = 1'b0;
    clr = fire && ok;
    unique case (state)
      RUN:     en = !fire;
      default: en = 1'b0;
    endcase
  end

  always_comb begin
    t_inc = t;
    wrap  = 1'b0;
    if (t.sr != UNITS_MAX) begin
      t_inc.sr = t.sr + 4'd1;
    end else begin
      t_inc.sr = '0;
      if (t.sl != SEC_TENS_MAX) begin
        t_inc.sl = t.sl + 3'd1;
      end else begin
        t_inc.sl = '0;
        if (t.mr != UNITS_MAX) begin
          t_inc.mr = t.mr + 4'd1;
        end else begin
          t_inc.mr = '0;
          if (t.ml != SEC_TENS_MAX) begin
            t_inc.ml = t.ml + 3'd1;
          end else begin
            t_inc.ml = '0;
            unique case (1'b1)
              (t.hl == HOUR_TENS_MAX &&
               t.hr == HOUR_UNITS_MAX_AT_20): begin
                t_inc.hl = '0;
                t_inc.hr = '0;
                wrap     = 1'b1;
              end
              (t.hr == UNITS_MAX): begin
                t_inc.hr = '0;
                t_inc.hl = t.hl + 2'd1;
              end
              default: t_inc.hr = t.hr + 4'd1;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t         <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      ack_q     <= fire && ok;
      err_q     <= fire && !ok;
      sec_pulse <= tick;
      day_wrap  <= tick && wrap;
      if (fire && ok) begin
        t <= '{hl: ld.i_hours_left,
               hr: ld.i_hours_right,
               ml: ld.i_minutes_left,
               mr: ld.i_minutes_right,
               sl: 3'd0,
               sr: 4'd0};
      end else if (tick) begin
        t <= t_inc;
      end
    end
  end

  assign ld.load_ack      = ack_q;
  assign ld.load_err      = err_q;
  assign o_hours_left     = t.hl;
  assign o_hours_right    = t.hr;
  assign o_minutes_left   = t.ml;
  assign o_minutes_right  = t.mr;
  assign o_seconds_left   = t.sl;
  assign o_seconds_right  = t.sr;
endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed corner cases, a load
// table and random traffic against a seconds-of-day model.
module tb_time_keeper;
  localparam int TPS = 4;

  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic [1:0] o_hl;
  logic [3:0] o_hr;
  logic [2:0] o_ml;
  logic [3:0] o_mr;
  logic [2:0] o_sl;
  logic [3:0] o_sr;
  logic sec_pulse, day_wrap;

  time_keeper_if bus();

  time_keeper #(.TICKS_PER_SEC(TPS)) dut (
    .clk            (clk),
    .rst            (rst),
    .hold           (hold),
    .ld             (bus),
    .o_hours_left   (o_hl),
    .o_hours_right  (o_hr),
    .o_minutes_left (o_ml),
    .o_minutes_right(o_mr),
    .o_seconds_left (o_sl),
    .o_seconds_right(o_sr),
    .sec_pulse      (sec_pulse),
    .day_wrap       (day_wrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference: time as seconds since midnight
  int m_tod, m_pre;
  bit m_frozen, m_resp;
  bit m_ack, m_err, m_sp, m_dw;

  typedef struct {
    logic [1:0]  hl;
    logic [3:0]  hr;
    logic [2:0]  ml;
    logic [3:0]  mr;
    bit          ack;
    logic [23:0] t_after;
  } vec_t;

  function automatic logic [23:0] tod_hex(int s);
    int h, m, sc;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    return {4'(h / 10), 4'(h % 10),
            4'(m / 10), 4'(m % 10),
            4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic logic [23:0] cur_time();
    return {2'b0, o_hl, o_hr, 1'b0, o_ml, o_mr,
            1'b0, o_sl, o_sr};
  endfunction

  function automatic bit valid_time(
    int hl, int hr, int ml, int mr);
    return hr <= 9 && mr <= 9 && ml <= 5 &&
           (hl * 10 + hr) < 24;
  endfunction

  task automatic check(string nm,
                       logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit h,
                     input bit lv,
                     input logic [1:0] hl,
                     input logic [3:0] hr,
                     input logic [2:0] ml,
                     input logic [3:0] mr);
    rst  = r;
    hold = h;
    bus.load_valid      = lv;
    bus.i_hours_left    = hl;
    bus.i_hours_right   = hr;
    bus.i_minutes_left  = ml;
    bus.i_minutes_right = mr;
    @(posedge clk);
    m_ack = 0; m_err = 0; m_sp = 0; m_dw = 0;
    if (r) begin
      m_tod = 0; m_pre = 0;
      m_frozen = 0; m_resp = 0;
    end else if (m_resp) begin
      m_resp   = 0;
      m_frozen = h;
    end else if (lv) begin
      if (valid_time(hl, hr, ml, mr)) begin
        m_tod = (hl * 10 + hr) * 3600 +
                (ml * 10 + mr) * 60;
        m_pre = 0;
        m_ack = 1;
      end else begin
        m_err = 1;
      end
      m_resp = 1;
    end else begin
      if (!m_frozen) begin
        if (m_pre == TPS - 1) begin
          m_pre = 0;
          m_tod = (m_tod + 1) % 86400;
          m_sp  = 1;
          m_dw  = (m_tod == 0);
        end else begin
          m_pre++;
        end
      end
      m_frozen = h;
    end
    #1;
    check("model",
          {4'b0, cur_time(), bus.load_ack,
           bus.load_err, sec_pulse, day_wrap},
          {4'b0, tod_hex(m_tod), m_ack, m_err,
           m_sp, m_dw});
  endtask

  task automatic idle(int n, bit h = 0);
    for (int i = 0; i < n; i++)
      cyc(0, h, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2, 4, 0, 0, 0, 24'h000000};
    tbl[1] = '{1, 9, 6, 0, 0, 24'h000000};
    tbl[2] = '{3, 0, 0, 0, 0, 24'h000000};
    tbl[3] = '{1, 9, 5, 9, 1, 24'h195900};
    tbl[4] = '{0, 0, 0, 10, 0, 24'h195900};
    tbl[5] = '{2, 3, 5, 9, 1, 24'h235900};
    tbl[6] = '{2, 0, 0, 0, 1, 24'h200000};
    tbl[7] = '{2, 4, 5, 9, 0, 24'h200000};
    tbl[8] = '{1, 12, 0, 0, 0, 24'h200000};

    // reset and first seconds
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_time", {8'b0, cur_time()}, 0);
    check("rst_pulse",
          {bus.load_ack, bus.load_err,
           sec_pulse, day_wrap}, 0);
    idle(4);
    check("first_sec", {8'b0, cur_time()},
          32'h000001);
    check("first_pulse", sec_pulse, 1);
    idle(239 * TPS);
    check("t240", {8'b0, cur_time()}, 32'h000400);

    // day wrap
    cyc(0, 0, 1, 2, 3, 5, 9);
    check("ld2359_ack", bus.load_ack, 1);
    check("ld2359_t", {8'b0, cur_time()},
          32'h235900);
    idle(1 + 59 * TPS + (TPS - 1));
    check("pre_wrap", day_wrap, 0);
    idle(1);
    check("wrap_t", {8'b0, cur_time()}, 0);
    check("wrap_dw", day_wrap, 1);
    idle(1);
    check("wrap_dw_once", day_wrap, 0);

    // load validity table, frozen under hold
    foreach (tbl[i]) begin
      cyc(0, 1, 1, tbl[i].hl, tbl[i].hr,
          tbl[i].ml, tbl[i].mr);
      check($sformatf("tbl%0d_resp", i),
            {bus.load_ack, bus.load_err},
            {tbl[i].ack, !tbl[i].ack});
      check($sformatf("tbl%0d_t", i),
            {8'b0, cur_time()},
            {8'b0, tbl[i].t_after});
      idle(1, 1);
    end
    idle(2);

    // load coincident with a tick
    cyc(0, 0, 1, 1, 2, 3, 4);
    idle(1 + 56 * TPS);
    check("t123456", {8'b0, cur_time()},
          32'h123456);
    idle(TPS - 1);
    cyc(0, 0, 1, 1, 2, 3, 4);
    check("coll_t", {8'b0, cur_time()},
          32'h123400);
    check("coll_sp", sec_pulse, 0);
    check("coll_ack", bus.load_ack, 1);
    for (int i = 0; i < TPS; i++) begin
      idle(1);
      check($sformatf("coll_wait%0d", i),
            sec_pulse, 0);
    end
    idle(1);
    check("coll_tick", sec_pulse, 1);
    check("coll_tick_t", {8'b0, cur_time()},
          32'h123401);

    // hold two cycles into a second
    idle(2);
    idle(10, 1);
    check("hold_t", {8'b0, cur_time()},
          32'h123401);
    idle(1);
    check("rel1_sp", sec_pulse, 0);
    idle(1);
    check("rel2_sp", sec_pulse, 1);
    check("rel2_t", {8'b0, cur_time()},
          32'h123402);

    // reset beats a pending load
    cyc(1, 0, 1, 1, 2, 3, 4);
    check("rstld_t", {8'b0, cur_time()}, 0);
    check("rstld_resp",
          {bus.load_ack, bus.load_err}, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0,
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 11)),
          3'($urandom_range(0, 6)),
          4'($urandom_range(0, 11)));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
